// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives requests to a variable-latency
// instruction memory and presents {pc_plus4, instr, instr_valid} to IF/ID every cycle.
// IF/ID has no enable, so a stall is handled by re-presenting the held instruction.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StDrain
    } state_e;

    localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        redirect;
    logic [31:0] redirect_sel;
    logic [31:0] redirect_pc;
    logic [31:0] pc_inc;

    // Redirect target selection; branch wins over jump, word-aligned.
    always_comb begin
        redirect     = branch_taken | jump;
        redirect_sel = branch_taken ? branch_target : jump_target;
        redirect_pc  = {redirect_sel[31:2], 2'b00};
        pc_inc       = pc_q + 32'd4;
    end

    // Next-state, memory request and IF/ID outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_pc4_d   = hold_pc4_q;
        hold_instr_d = hold_instr_q;
        stale_addr_d = stale_addr_q;
        wait_cnt_d   = 4'd0;
        fault_d      = fault_q;
        count_d      = count_q;

        imem_req     = 1'b0;
        imem_addr    = pc_q;
        pc_plus4     = pc_inc;
        instr        = NOP_INSTR;
        instr_valid  = 1'b0;

        unique case (state_q)
            StFetch, StWait: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d    = redirect_pc;
                        state_d = StFetch;
                    end else begin
                        instr       = imem_rdata;
                        instr_valid = 1'b1;
                        if (stall) begin
                            hold_pc4_d   = pc_inc;
                            hold_instr_d = imem_rdata;
                            state_d      = StHold;
                        end else begin
                            pc_d    = pc_inc;
                            count_d = count_q + 32'd1;
                            state_d = StFetch;
                        end
                    end
                end else if (redirect) begin
                    // Outstanding request must still complete; remember its address.
                    stale_addr_d = pc_q;
                    pc_d         = redirect_pc;
                    state_d      = StDrain;
                end else begin
                    state_d = StWait;
                    if (state_q == StWait) begin
                        wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
                        if (wait_cnt_d == MaxWaitCnt) begin
                            fault_d = 1'b1;
                        end
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else begin
                    pc_plus4    = hold_pc4_q;
                    instr       = hold_instr_q;
                    instr_valid = 1'b1;
                    if (!stall) begin
                        pc_d    = pc_inc;
                        count_d = count_q + 32'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = stale_addr_q;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ready) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset abandons any request and presents a bubble at the reset PC.
        if (reset) begin
            imem_req    = 1'b0;
            imem_addr   = RESET_PC;
            pc_plus4    = RESET_PC + 32'd4;
            instr       = NOP_INSTR;
            instr_valid = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            hold_pc4_q   <= 32'd0;
            hold_instr_q <= 32'd0;
            stale_addr_q <= 32'd0;
            wait_cnt_q   <= 4'd0;
            fault_q      <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc4_q   <= hold_pc4_d;
            hold_instr_q <= hold_instr_d;
            stale_addr_q <= stale_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed stimulus, a transaction-level model of the
// fetch stage checked every cycle, and hand-computed pins at key cycles.
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned MAX_WAIT  = 15;
    localparam logic [31:0] MEM_KEY   = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    // Memory responder: either echoes addr^key or returns a directed word.
    logic        mem_mode = 1'b0;
    logic [31:0] rdata_drv = 32'd0;
    assign imem_rdata = mem_mode ? (imem_addr ^ MEM_KEY) : rdata_drv;

    int total = 0;
    int bad = 0;
    logic started = 1'b0;

    // Hand-computed expectations for the current cycle.
    logic        pin_en = 1'b0;
    logic [31:0] pin_pc4, pin_instr, pin_addr, pin_cnt;
    logic        pin_req, pin_valid, pin_flt;

    instr_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model: PC, a held instruction (stalled), an outstanding stale request, a not-ready run.
    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_held_instr, m_stale_addr;
    logic        m_held, m_stale, m_fault;
    int          m_run;
    logic [31:0] m_count;

    // Compare process: predict outputs from the model, check, then advance the model.
    always @(negedge clock) begin
        logic        redir, e_req, e_valid;
        logic [31:0] tgt, e_addr, e_pc4, e_instr;
        redir = branch_taken | jump;
        tgt   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
        if (started) begin
            e_pc4 = m_pc + 32'd4;
            e_instr = NOP_INSTR;
            e_valid = 1'b0;
            e_addr = m_pc;
            e_req = 1'b1;
            if (reset) begin
                e_req = 1'b0;
                e_pc4 = RESET_PC + 32'd4;
            end else if (m_held) begin
                e_req = 1'b0;
                if (!redir) begin
                    e_instr = m_held_instr;
                    e_valid = 1'b1;
                end
            end else if (m_stale) begin
                e_addr = m_stale_addr;
            end else if (imem_ready && !redir) begin
                e_instr = imem_rdata;
                e_valid = 1'b1;
            end
            check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) check("imem_addr", imem_addr, e_addr);
            check("pc_plus4", pc_plus4, e_pc4);
            check("instr", instr, e_instr);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
            if (m_init) begin
                check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
                check("fetch_count", fetch_count, m_count);
            end
            if (pin_en) begin
                check("pin_model_pc4", e_pc4, pin_pc4);
                check("pin_model_instr", e_instr, pin_instr);
                check("pin_pc4", pc_plus4, pin_pc4);
                check("pin_instr", instr, pin_instr);
                check("pin_valid", {31'd0, instr_valid}, {31'd0, pin_valid});
                check("pin_req", {31'd0, imem_req}, {31'd0, pin_req});
                if (pin_req) check("pin_addr", imem_addr, pin_addr);
                check("pin_count", fetch_count, pin_cnt);
                check("pin_fault", {31'd0, fetch_fault}, {31'd0, pin_flt});
            end
        end
        // Advance the model across the coming rising edge.
        if (reset) begin
            m_init = 1'b1; m_pc = RESET_PC; m_held = 1'b0; m_stale = 1'b0;
            m_run = 0; m_fault = 1'b0; m_count = 32'd0;
        end else if (m_held) begin
            if (redir) begin
                m_pc = tgt; m_held = 1'b0;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4; m_count = m_count + 32'd1; m_held = 1'b0;
            end
        end else if (m_stale) begin
            if (redir) m_pc = tgt;
            if (imem_ready) m_stale = 1'b0;
        end else if (imem_ready) begin
            m_run = 0;
            if (redir) m_pc = tgt;
            else if (stall) begin
                m_held = 1'b1; m_held_instr = imem_rdata;
            end else begin
                m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
            end
        end else if (redir) begin
            m_stale = 1'b1; m_stale_addr = m_pc; m_pc = tgt; m_run = 0;
        end else begin
            m_run++;
            if (m_run > int'(MAX_WAIT)) m_fault = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input logic [31:0] pc4, input logic [31:0] ins, input logic [31:0] addr,
                       input logic req, input logic vld, input logic [31:0] cnt, input logic flt);
        pin_pc4 = pc4; pin_instr = ins; pin_addr = addr; pin_req = req;
        pin_valid = vld; pin_cnt = cnt; pin_flt = flt; pin_en = 1'b1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        started = 1'b1;
        // Reset: bubble at RESET_PC, no request.
        pin(32'h4, NOP_INSTR, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        // Zero-wait memory: one instruction per cycle.
        reset = 1'b0; mem_mode = 1'b1; imem_ready = 1'b1;
        pin(32'h4, 32'hA5A5_0000, 32'h0, 1'b1, 1'b1, 32'd0, 1'b0);
        tick();
        tick();
        pin(32'hC, 32'hA5A5_0008, 32'h8, 1'b1, 1'b1, 32'd2, 1'b0);
        tick();
        tick();
        // Three wait cycles at 0x10.
        mem_mode = 1'b0; imem_ready = 1'b0; rdata_drv = 32'h1234_0010;
        tick();
        pin(32'h14, NOP_INSTR, 32'h10, 1'b1, 1'b0, 32'd4, 1'b0);
        tick();
        tick();
        imem_ready = 1'b1;
        pin(32'h14, 32'h1234_0010, 32'h10, 1'b1, 1'b1, 32'd4, 1'b0);
        tick();
        mem_mode = 1'b1;
        repeat (3) tick();
        // Two-cycle stall on the instruction at 0x20.
        stall = 1'b1;
        pin(32'h24, 32'hA5A5_0020, 32'h20, 1'b1, 1'b1, 32'd8, 1'b0);
        tick();
        pin(32'h24, 32'hA5A5_0020, 32'h0, 1'b0, 1'b1, 32'd8, 1'b0);
        tick();
        stall = 1'b0;
        pin(32'h24, 32'hA5A5_0020, 32'h0, 1'b0, 1'b1, 32'd8, 1'b0);
        tick();
        pin(32'h28, 32'hA5A5_0024, 32'h24, 1'b1, 1'b1, 32'd9, 1'b0);
        repeat (3) tick();
        // Branch while waiting at 0x30: drain the stale fetch, then fetch 0x100.
        mem_mode = 1'b0; imem_ready = 1'b0; rdata_drv = 32'hDEAD_BEEF;
        tick();
        branch_taken = 1'b1; branch_target = 32'h103;
        pin(32'h34, NOP_INSTR, 32'h30, 1'b1, 1'b0, 32'd12, 1'b0);
        tick();
        branch_taken = 1'b0;
        pin(32'h104, NOP_INSTR, 32'h30, 1'b1, 1'b0, 32'd12, 1'b0);
        tick();
        imem_ready = 1'b1;
        pin(32'h104, NOP_INSTR, 32'h30, 1'b1, 1'b0, 32'd12, 1'b0);
        tick();
        mem_mode = 1'b1;
        pin(32'h104, 32'hA5A5_0100, 32'h100, 1'b1, 1'b1, 32'd12, 1'b0);
        tick();
        // Branch, jump and stall together: branch wins, stall ignored.
        branch_taken = 1'b1; branch_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
        stall = 1'b1;
        pin(32'h108, NOP_INSTR, 32'h104, 1'b1, 1'b0, 32'd13, 1'b0);
        tick();
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        pin(32'h204, 32'hA5A5_0200, 32'h200, 1'b1, 1'b1, 32'd13, 1'b0);
        tick();
        jump = 1'b1; jump_target = 32'h402;
        tick();
        jump = 1'b0;
        pin(32'h404, 32'hA5A5_0400, 32'h400, 1'b1, 1'b1, 32'd14, 1'b0);
        tick();
        // Jump out of a held stall.
        stall = 1'b1;
        tick();
        jump = 1'b1; jump_target = 32'h500;
        pin(32'h408, NOP_INSTR, 32'h0, 1'b0, 1'b0, 32'd15, 1'b0);
        tick();
        jump = 1'b0; stall = 1'b0;
        pin(32'h504, 32'hA5A5_0500, 32'h500, 1'b1, 1'b1, 32'd15, 1'b0);
        tick();
        // Long wait at the top of memory: fault, then PC wraps to 0.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0; mem_mode = 1'b0; imem_ready = 1'b0; rdata_drv = 32'h0BAD_F00D;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) pin(32'h0, NOP_INSTR, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd16, 1'b0);
            tick();
        end
        imem_ready = 1'b1;
        pin(32'h0, 32'h0BAD_F00D, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'd16, 1'b1);
        tick();
        mem_mode = 1'b1;
        pin(32'h4, 32'hA5A5_0000, 32'h0, 1'b1, 1'b1, 32'd17, 1'b1);
        tick();
        // Reset in the middle of a wait drops the request and clears the fault.
        mem_mode = 1'b0; imem_ready = 1'b0;
        tick();
        reset = 1'b1;
        pin(32'h4, NOP_INSTR, 32'h0, 1'b0, 1'b0, 32'd18, 1'b1);
        tick();
        reset = 1'b0; mem_mode = 1'b1; imem_ready = 1'b1;
        pin(32'h4, 32'hA5A5_0000, 32'h0, 1'b1, 1'b1, 32'd0, 1'b0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
